multicycle_ctrl_rv32i: RTL and testbench

Multi-cycle control FSM for the RV32I datapath. Sequences fetch, decode, execute, memory and writeback. Drives the branch unit's enable and branch-type code, and the PC, IR, register-file and data-memory strobes. Handshakes with instruction and data memories that have variable latency, and counts retired instructions.

---
 rtl/rv32i_ctrl_pkg.sv | 36 +++
 rtl/multicycle_ctrl_rv32i_if.sv | 46 ++++
 rtl/branch_type_decoder_rv32i.sv | 25 ++
 rtl/multicycle_ctrl_rv32i.sv | 174 +++++++++++++++++
 tb/tb_multicycle_ctrl_rv32i.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// branch-type codes and writeback-source selects.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  // StTrap is only reachable when the illegal-instruction trap is built in.
  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  localparam logic [2:0] BtBeq  = 3'b000;
  localparam logic [2:0] BtBge  = 3'b001;
  localparam logic [2:0] BtBgeu = 3'b010;
  localparam logic [2:0] BtBlt  = 3'b011;
  localparam logic [2:0] BtBltu = 3'b100;
  localparam logic [2:0] BtBne  = 3'b101;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_rv32i_if.sv
// Control-unit bus: decoded IR fields and memory handshakes in, datapath strobes out.
// Optional: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds the illegal_instr signal.
interface multicycle_ctrl_rv32i_if #(
  parameter int unsigned RETIRE_CNT_W = 32
);
  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic                    imem_ready;
  logic                    dmem_ready;
  logic                    imem_req;
  logic                    cu_irwrite;
  logic                    cu_pcwrite;
  logic                    cu_branch;
  logic [2:0]              cu_branchtype;
  logic                    cu_jump;
  logic                    cu_regwrite;
  logic                    cu_memread;
  logic                    cu_memwrite;
  logic [1:0]              cu_wbsel;
  logic                    cu_alusrc;
  logic [RETIRE_CNT_W-1:0] retired;
  logic [2:0]              state_dbg;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic                    illegal_instr;
`endif

  // Controller side.
  modport master (
    input  opcode, funct3, imem_ready, dmem_ready,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output illegal_instr,
`endif
    output imem_req, cu_irwrite, cu_pcwrite, cu_branch, cu_branchtype, cu_jump,
           cu_regwrite, cu_memread, cu_memwrite, cu_wbsel, cu_alusrc, retired, state_dbg
  );

  // Datapath / memory side.
  modport slave (
    output opcode, funct3, imem_ready, dmem_ready,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    input  illegal_instr,
`endif
    input  imem_req, cu_irwrite, cu_pcwrite, cu_branch, cu_branchtype, cu_jump,
           cu_regwrite, cu_memread, cu_memwrite, cu_wbsel, cu_alusrc, retired, state_dbg
  );
endinterface

// File: rtl/branch_type_decoder_rv32i.sv
// Maps BRANCH funct3 onto the branch unit's type code; funct3 010/011 are invalid.
module branch_type_decoder_rv32i
  import rv32i_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  output logic       valid,
  output logic [2:0] branchtype
);

  // Pure lookup table.
  always_comb begin
    valid      = 1'b1;
    branchtype = BtBeq;
    case (funct3)
      3'b000:  branchtype = BtBeq;
      3'b001:  branchtype = BtBne;
      3'b100:  branchtype = BtBlt;
      3'b101:  branchtype = BtBge;
      3'b110:  branchtype = BtBltu;
      3'b111:  branchtype = BtBgeu;
      default: valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_rv32i.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK].
// Strobes are decoded combinationally from the state register and IR fields.
// Optional: define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to lock into TRAP on an illegal
// instruction instead of retiring it as a NOP.
module multicycle_ctrl_rv32i
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input logic                    clock,
  input logic                    reset,
  multicycle_ctrl_rv32i_if.master bus
);

  state_e                  state_q, state_d;
  logic [RETIRE_CNT_W-1:0] retired_q;
  logic                    bt_valid;
  logic [2:0]              bt_code;
  logic                    is_load;
  logic                    illegal;
  logic                    imem_req, irwrite, pcwrite, branch, jump;
  logic                    regwrite, memread, memwrite, alusrc;
  logic [2:0]              branchtype;
  logic [1:0]              wbsel;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic                    in_trap;
`endif

  branch_type_decoder_rv32i u_bt_dec (
    .funct3     (bus.funct3),
    .valid      (bt_valid),
    .branchtype (bt_code)
  );

  assign is_load = (bus.opcode == OpcLoad);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Retired-instruction counter: every PC write retires exactly one instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        retired_q <= '0;
    else if (pcwrite) retired_q <= retired_q + RETIRE_CNT_W'(1);
  end

  // Next state and strobes; everything is forced low while reset is high.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchtype = BtBeq;
    jump       = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    wbsel      = WbAlu;
    alusrc     = 1'b0;
    illegal    = 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    in_trap    = 1'b0;
`endif
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          irwrite = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        case (bus.opcode)
          OpcBranch: begin
            if (bt_valid) begin
              branch     = 1'b1;
              branchtype = bt_code;
              pcwrite    = 1'b1;
              state_d    = StFetch;
            end else begin
              illegal = 1'b1;
            end
          end
          OpcJal, OpcJalr: begin
            jump     = 1'b1;
            pcwrite  = 1'b1;
            regwrite = 1'b1;
            wbsel    = WbPc4;
            state_d  = StFetch;
          end
          OpcLoad, OpcStore: begin
            alusrc  = 1'b1;
            state_d = StMem;
          end
          OpcOp: state_d = StWriteback;
          OpcOpImm, OpcLui, OpcAuipc: begin
            alusrc  = 1'b1;
            state_d = StWriteback;
          end
          default: illegal = 1'b1;
        endcase
        if (illegal) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          // Retire as a NOP: PC advances through the branch unit with branch disabled.
          pcwrite = 1'b1;
          state_d = StFetch;
`endif
        end
      end
      StMem: begin
        memread  = is_load;
        memwrite = !is_load;
        if (bus.dmem_ready) begin
          if (is_load) begin
            state_d = StWriteback;
          end else begin
            pcwrite = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StWriteback: begin
        regwrite = 1'b1;
        pcwrite  = 1'b1;
        wbsel    = is_load ? WbMem : WbAlu;
        state_d  = StFetch;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      StTrap: in_trap = 1'b1;
`endif
      default: state_d = StFetch;
    endcase
    if (reset) begin
      imem_req   = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branchtype = BtBeq;
      jump       = 1'b0;
      regwrite   = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      wbsel      = WbAlu;
      alusrc     = 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      in_trap    = 1'b0;
`endif
    end
  end

  assign bus.imem_req      = imem_req;
  assign bus.cu_irwrite    = irwrite;
  assign bus.cu_pcwrite    = pcwrite;
  assign bus.cu_branch     = branch;
  assign bus.cu_branchtype = branchtype;
  assign bus.cu_jump       = jump;
  assign bus.cu_regwrite   = regwrite;
  assign bus.cu_memread    = memread;
  assign bus.cu_memwrite   = memwrite;
  assign bus.cu_wbsel      = wbsel;
  assign bus.cu_alusrc     = alusrc;
  assign bus.retired       = retired_q;
  assign bus.state_dbg     = state_q;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_instr = in_trap;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_rv32i.sv
// Self-checking bench for multicycle_ctrl_rv32i. A small retired-counter width is used
// so that wrap-around is exercised. Expected per-cycle strobes come from an instruction-
// level model: each instruction is expanded into its phase list from the opcode rules.
module tb_multicycle_ctrl_rv32i;

  localparam int unsigned CW   = 4;
  localparam int          WRAP = 1 << CW;

  typedef struct packed {
    logic       imem_req;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [2:0] btype;
    logic       jump;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] wbsel;
    logic       alusrc;
    logic [2:0] st;
  } vec_t;

  typedef enum int {KBranch, KJump, KLoad, KStore, KAluReg, KAluImm, KNop} kind_e;

  logic clock;
  logic reset;

  multicycle_ctrl_rv32i_if #(.RETIRE_CNT_W(CW)) bus ();

  multicycle_ctrl_rv32i #(.RETIRE_CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_checks;
  int   n_fail;
  int   ret_model;
  vec_t exp_q[$];
  vec_t obs_q[$];
  vec_t msk_q[$];
  int   eret_q[$];
  int   oret_q[$];

  function automatic vec_t observe();
    vec_t v;
    v.imem_req = bus.imem_req;
    v.irwrite  = bus.cu_irwrite;
    v.pcwrite  = bus.cu_pcwrite;
    v.branch   = bus.cu_branch;
    v.btype    = bus.cu_branchtype;
    v.jump     = bus.cu_jump;
    v.regwrite = bus.cu_regwrite;
    v.memread  = bus.cu_memread;
    v.memwrite = bus.cu_memwrite;
    v.wbsel    = bus.cu_wbsel;
    v.alusrc   = bus.cu_alusrc;
    v.st       = bus.state_dbg;
    return v;
  endfunction

  // Fields only meaningful in some cycles: branch type with branch, wbsel with regwrite,
  // ALU operand select in EXECUTE.
  function automatic vec_t care(vec_t e);
    vec_t m;
    m = '1;
    if (!e.branch) m.btype = '0;
    if (!e.regwrite) m.wbsel = '0;
    if (e.st != 3'd2) m.alusrc = 1'b0;
    return m;
  endfunction

  // {valid, branch type code} for a BRANCH funct3.
  function automatic logic [3:0] bt_lookup(logic [2:0] f3);
    case (f3)
      3'b000:  return 4'b1000;
      3'b001:  return 4'b1101;
      3'b100:  return 4'b1011;
      3'b101:  return 4'b1001;
      3'b110:  return 4'b1100;
      3'b111:  return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic kind_e classify(logic [6:0] op, logic [2:0] f3);
    logic [3:0] b;
    b = bt_lookup(f3);
    case (op)
      7'b1100011:                         return b[3] ? KBranch : KNop;
      7'b1101111, 7'b1100111:             return KJump;
      7'b0000011:                         return KLoad;
      7'b0100011:                         return KStore;
      7'b0110011:                         return KAluReg;
      7'b0010011, 7'b0110111, 7'b0010111: return KAluImm;
      default:                            return KNop;
    endcase
  endfunction

  function automatic logic [6:0] legal_op(int i);
    case (i)
      0:       return 7'b1100011;
      1:       return 7'b1101111;
      2:       return 7'b1100111;
      3:       return 7'b0000011;
      4:       return 7'b0100011;
      5:       return 7'b0110011;
      6:       return 7'b0010011;
      7:       return 7'b0110111;
      default: return 7'b0010111;
    endcase
  endfunction

  // One clock cycle: drive inputs after the falling edge, record observed vs expected.
  task automatic cycle(input logic [6:0] op, input logic [2:0] f3, input logic ir,
                       input logic dr, input vec_t e);
    @(negedge clock);
    bus.opcode     = op;
    bus.funct3     = f3;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    #1;
    exp_q.push_back(e);
    obs_q.push_back(observe());
    msk_q.push_back(care(e));
    eret_q.push_back(ret_model);
    oret_q.push_back(int'(bus.retired));
    if (e.pcwrite) ret_model = (ret_model + 1) % WRAP;
  endtask

  // Expand one instruction into its phases, with iwait/dwait memory wait states.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int iwait,
                           input int dwait);
    kind_e      k;
    vec_t       e;
    logic [3:0] b;
    k = classify(op, f3);
    b = bt_lookup(f3);
    for (int i = 0; i <= iwait; i++) begin
      e = '0;
      e.imem_req = 1'b1;
      e.irwrite  = (i == iwait);
      cycle(7'($urandom), 3'($urandom), (i == iwait), 1'($urandom), e);
    end
    e = '0;
    e.st = 3'd1;
    cycle(op, f3, 1'($urandom), 1'($urandom), e);
    e = '0;
    e.st = 3'd2;
    case (k)
      KBranch: begin
        e.branch  = 1'b1;
        e.btype   = b[2:0];
        e.pcwrite = 1'b1;
      end
      KJump: begin
        e.jump     = 1'b1;
        e.pcwrite  = 1'b1;
        e.regwrite = 1'b1;
        e.wbsel    = 2'b10;
      end
      KLoad, KStore, KAluImm: e.alusrc = 1'b1;
      KAluReg:                e.alusrc = 1'b0;
      default:                e.pcwrite = 1'b1;
    endcase
    cycle(op, f3, 1'($urandom), 1'($urandom), e);
    if (k == KLoad || k == KStore) begin
      for (int i = 0; i <= dwait; i++) begin
        e = '0;
        e.st       = 3'd3;
        e.memread  = (k == KLoad);
        e.memwrite = (k == KStore);
        e.pcwrite  = (k == KStore) && (i == dwait);
        cycle(op, f3, 1'($urandom), (i == dwait), e);
      end
    end
    if (k == KLoad || k == KAluReg || k == KAluImm) begin
      e = '0;
      e.st       = 3'd4;
      e.regwrite = 1'b1;
      e.pcwrite  = 1'b1;
      e.wbsel    = (k == KLoad) ? 2'b01 : 2'b00;
      cycle(op, f3, 1'($urandom), 1'($urandom), e);
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    msk_q.delete();
    eret_q.delete();
    oret_q.delete();
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.opcode = 7'($urandom);
      bus.funct3 = 3'($urandom);
      #1;
      n_checks++;
      if (observe() !== '0) begin
        n_fail++;
        $display("FAIL reset outputs cycle %0d: got %h, expected 0", i, observe());
      end
      n_checks++;
      if (bus.retired !== '0) begin
        n_fail++;
        $display("FAIL reset retired cycle %0d: got %0d, expected 0", i, bus.retired);
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      n_checks++;
      if (bus.illegal_instr !== 1'b0) begin
        n_fail++;
        $display("FAIL reset illegal_instr: got %b, expected 0", bus.illegal_instr);
      end
`endif
    end
    @(negedge clock);
    reset          = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL reset release: imem_req %b state %0d, expected 1 and 0",
               bus.imem_req, bus.state_dbg);
    end
    ret_model = 0;
  endtask

  task automatic test_branch();
    clear_q();
    run_instr(7'b1100011, 3'b000, 0, 0);
    run_instr(7'b1100011, 3'b111, 0, 0);
    run_instr(7'b1100011, 3'b001, 1, 0);
    run_instr(7'b1100011, 3'b100, $urandom_range(0, 3), 0);
    run_instr(7'b1100011, 3'b101, $urandom_range(0, 3), 0);
    run_instr(7'b1100011, 3'b110, $urandom_range(0, 3), 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        n_fail++;
        $display("FAIL branch strobes cycle %0d: got %h, expected %h", i,
                 obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
      n_checks++;
      if (oret_q[i] !== eret_q[i]) begin
        n_fail++;
        $display("FAIL branch retired cycle %0d: got %0d, expected %0d", i, oret_q[i], eret_q[i]);
      end
    end
  endtask

  task automatic test_jump_alu();
    clear_q();
    run_instr(7'b1101111, 3'($urandom), $urandom_range(0, 3), 0);
    run_instr(7'b1100111, 3'b000, $urandom_range(0, 3), 0);
    run_instr(7'b0110011, 3'($urandom), $urandom_range(0, 3), 0);
    run_instr(7'b0010011, 3'($urandom), $urandom_range(0, 3), 0);
    run_instr(7'b0110111, 3'($urandom), $urandom_range(0, 3), 0);
    run_instr(7'b0010111, 3'($urandom), $urandom_range(0, 3), 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        n_fail++;
        $display("FAIL jump_alu strobes cycle %0d: got %h, expected %h", i,
                 obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
      n_checks++;
      if (oret_q[i] !== eret_q[i]) begin
        n_fail++;
        $display("FAIL jump_alu retired cycle %0d: got %0d, expected %0d", i,
                 oret_q[i], eret_q[i]);
      end
    end
  endtask

  task automatic test_load_store();
    clear_q();
    run_instr(7'b0000011, 3'b010, 0, 3);
    run_instr(7'b0000011, 3'b000, 1, 0);
    run_instr(7'b0100011, 3'b010, 0, 0);
    run_instr(7'b0100011, 3'b001, 0, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        n_fail++;
        $display("FAIL load_store strobes cycle %0d: got %h, expected %h", i,
                 obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
      n_checks++;
      if (oret_q[i] !== eret_q[i]) begin
        n_fail++;
        $display("FAIL load_store retired cycle %0d: got %0d, expected %0d", i,
                 oret_q[i], eret_q[i]);
      end
    end
  endtask

`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  task automatic test_nop();
    clear_q();
    run_instr(7'b1100011, 3'b010, 0, 0);
    run_instr(7'b1100011, 3'b011, 0, 0);
    run_instr(7'b0000000, 3'($urandom), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        n_fail++;
        $display("FAIL nop strobes cycle %0d: got %h, expected %h", i,
                 obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
      n_checks++;
      if (oret_q[i] !== eret_q[i]) begin
        n_fail++;
        $display("FAIL nop retired cycle %0d: got %0d, expected %0d", i, oret_q[i], eret_q[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [6:0] op;
    logic [2:0] f3;
    clear_q();
    for (int n = 0; n < 60; n++) begin
      op = legal_op($urandom_range(0, 8));
      f3 = 3'($urandom);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      if (op == 7'b1100011 && f3[2:1] == 2'b01) f3 = 3'b000;
`else
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
`endif
      run_instr(op, f3, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        n_fail++;
        $display("FAIL random strobes cycle %0d: got %h, expected %h", i,
                 obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
      n_checks++;
      if (oret_q[i] !== eret_q[i]) begin
        n_fail++;
        $display("FAIL random retired cycle %0d: got %0d, expected %0d", i, oret_q[i], eret_q[i]);
      end
    end
  endtask

  task automatic test_reset_in_mem();
    vec_t e;
    clear_q();
    e = '0;
    e.imem_req = 1'b1;
    e.irwrite  = 1'b1;
    cycle(7'($urandom), 3'($urandom), 1'b1, 1'b0, e);
    e = '0;
    e.st = 3'd1;
    cycle(7'b0100011, 3'b010, 1'b0, 1'b0, e);
    e = '0;
    e.st     = 3'd2;
    e.alusrc = 1'b1;
    cycle(7'b0100011, 3'b010, 1'b0, 1'b0, e);
    e = '0;
    e.st       = 3'd3;
    e.memwrite = 1'b1;
    cycle(7'b0100011, 3'b010, 1'b0, 1'b0, e);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        n_fail++;
        $display("FAIL mem_reset strobes cycle %0d: got %h, expected %h", i,
                 obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    // Reset and dmem_ready together, between clock edges: reset must win at once.
    #1;
    reset          = 1'b1;
    bus.dmem_ready = 1'b1;
    #1;
    n_checks++;
    if (observe() !== '0) begin
      n_fail++;
      $display("FAIL mem_reset immediate: got %h, expected 0", observe());
    end
    n_checks++;
    if (bus.retired !== '0) begin
      n_fail++;
      $display("FAIL mem_reset retired: got %0d, expected 0", bus.retired);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (observe() !== '0 || bus.retired !== '0) begin
      n_fail++;
      $display("FAIL mem_reset held: got %h retired %0d, expected 0 and 0", observe(),
               bus.retired);
    end
    reset          = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.imem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL mem_reset release: imem_req %b state %0d, expected 1 and 0",
               bus.imem_req, bus.state_dbg);
    end
    ret_model = 0;
  endtask

  task automatic test_illegal();
    clear_q();
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    begin
      vec_t e;
      e = '0;
      e.imem_req = 1'b1;
      e.irwrite  = 1'b1;
      cycle(7'($urandom), 3'($urandom), 1'b1, 1'b0, e);
      e = '0;
      e.st = 3'd1;
      cycle(7'b1111111, 3'($urandom), 1'b0, 1'b0, e);
      e = '0;
      e.st = 3'd2;
      cycle(7'b1111111, 3'($urandom), 1'b0, 1'b0, e);
      for (int i = 0; i < 5; i++) begin
        e = '0;
        e.st = 3'd5;
        cycle(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), e);
      end
      n_checks++;
      if (bus.illegal_instr !== 1'b1) begin
        n_fail++;
        $display("FAIL trap illegal_instr: got %b, expected 1", bus.illegal_instr);
      end
    end
`else
    run_instr(7'b1111111, 3'($urandom), 0, 0);
    run_instr(7'b0110011, 3'($urandom), 0, 0);
`endif
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        n_fail++;
        $display("FAIL illegal strobes cycle %0d: got %h, expected %h", i,
                 obs_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
      n_checks++;
      if (oret_q[i] !== eret_q[i]) begin
        n_fail++;
        $display("FAIL illegal retired cycle %0d: got %0d, expected %0d", i,
                 oret_q[i], eret_q[i]);
      end
    end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.illegal_instr !== 1'b0 || bus.state_dbg !== 3'd0) begin
      n_fail++;
      $display("FAIL trap exit: illegal_instr %b state %0d, expected 0 and 0",
               bus.illegal_instr, bus.state_dbg);
    end
    @(negedge clock);
    reset          = 1'b0;
    bus.imem_ready = 1'b0;
    ret_model      = 0;
`endif
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    ret_model      = 0;
    reset          = 1'b1;
    bus.opcode     = '0;
    bus.funct3     = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    test_reset();
    test_branch();
    test_jump_alu();
    test_load_store();
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    test_nop();
`endif
    test_random();
    test_reset_in_mem();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
